// File: rtl/yfcpu_imem_loader.sv
// Byte-stream loader for the yfcpu instruction memory: COUNT byte, then N big-endian words.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the last word.
module yfcpu_imem_loader #(
  parameter int IM_SIZE = 8,
  parameter int WORD_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [IM_SIZE-1:0] imem_addr,
  output logic [WORD_W-1:0]  imem_wdata,
  output logic               cpu_rst,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int unsigned DEPTH = 32'd1 << IM_SIZE;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_CSUM, S_RUN, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_RUN, S_ERR} state_t;
`endif

  state_t             state;
  logic [IM_SIZE-1:0] idx;
  logic [8:0]         remaining;
  logic [7:0]         hi_q;
  logic [8:0]         n_words;
  logic               too_big;
  logic               fire;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]         csum_q;
`else
  logic               fin_pend;
`endif

  assign fire    = in_valid & in_ready;
  assign n_words = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
  assign too_big = (32'(n_words) > DEPTH);

  // Byte capture: high byte of the word in flight and the running checksum
  always_ff @(posedge clk) begin
    if (fire && state == S_HI) hi_q <= in_data;
`ifdef LOADER_CHECKSUM_EN
    if (fire) begin
      if (state == S_IDLE || state == S_RUN)
        csum_q <= '0;
      else if (state == S_HI || state == S_LO)
        csum_q <= csum_q ^ in_data;
    end
`endif
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      idx        <= '0;
      remaining  <= '0;
`ifndef LOADER_CHECKSUM_EN
      fin_pend   <= 1'b0;
`endif
    end else begin
      imem_we  <= 1'b0;
      done     <= 1'b0;
      in_ready <= (state != S_ERR);
`ifndef LOADER_CHECKSUM_EN
      // Completion lands one cycle after the last write; a COUNT byte
      // accepted in that same cycle overrides busy/cpu_rst below.
      if (fin_pend) begin
        fin_pend <= 1'b0;
        done     <= 1'b1;
        busy     <= 1'b0;
        cpu_rst  <= 1'b0;
      end
`endif
      case (state)
        S_IDLE, S_RUN: begin
          if (fire) begin
            cpu_rst <= 1'b1;
            if (too_big) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              err      <= 1'b1;
              busy     <= 1'b0;
            end else begin
              state     <= S_HI;
              busy      <= 1'b1;
              idx       <= '0;
              remaining <= n_words;
            end
          end
        end
        S_HI: begin
          if (fire) state <= S_LO;
        end
        S_LO: begin
          if (fire) begin
            imem_we    <= 1'b1;
            imem_addr  <= idx;
            imem_wdata <= {hi_q, in_data};
            idx        <= idx + 1'b1;
            remaining  <= remaining - 9'd1;
            if (remaining == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              state    <= S_RUN;
              fin_pend <= 1'b1;
`endif
            end else begin
              state <= S_HI;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (fire) begin
            busy <= 1'b0;
            if (in_data == csum_q) begin
              state   <= S_RUN;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end
          end
        end
`endif
        S_ERR: begin
          in_ready <= 1'b0;
        end
        default: state <= S_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_yfcpu_imem_loader.sv
// Self-checking bench for yfcpu_imem_loader: vector table, hand-written corner sequences,
// and randomized frames checked against a frame-level model of the expected IMEM writes.
module tb_yfcpu_imem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_valid4 = 1'b0;
  logic [7:0]  in_data = '0, in_data4 = '0;
  logic        in_ready, imem_we, cpu_rst, busy, done, err;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        in_ready4, imem_we4, cpu_rst4, busy4, done4, err4;
  logic [3:0]  imem_addr4;
  logic [15:0] imem_wdata4;

  yfcpu_imem_loader #(.IM_SIZE(8), .WORD_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err));

  yfcpu_imem_loader #(.IM_SIZE(4), .WORD_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
    .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
    .cpu_rst(cpu_rst4), .busy(busy4), .done(done4), .err(err4));

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed activity, sampled mid-cycle
  logic [7:0]  wa_q[$];
  logic [15:0] wd_q[$];
  int          wc_q[$];
  int          done_cnt = 0, done_cyc = -1, we4_cnt = 0, done4_cnt = 0, busy_viol = 0;
  logic        rst_at_done = 1'b1;
  logic [3:0]  last_a4 = '0;

  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(imem_addr); wd_q.push_back(imem_wdata); wc_q.push_back(cyc);
    end
    if (done) begin done_cnt++; done_cyc = cyc; rst_at_done = cpu_rst; end
    if (imem_we4) begin we4_cnt++; last_a4 = imem_addr4; end
    if (done4) done4_cnt++;
    if (!rst && ((busy && !in_ready) || (busy4 && !in_ready4))) busy_viol++;
  end

  // Expected words of the frame in flight (the reference model)
  logic [15:0] fw[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    done_cnt = 0; done_cyc = -1; we4_cnt = 0; done4_cnt = 0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    in_valid = 1'b0; in_valid4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
  endtask

  function automatic int gapv(input int m);
    if (m == 0) return 0;
    if (m == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  // Starts and ends 1 time unit after a rising edge
  task automatic send(input int sel, input logic [7:0] b, input int gap);
    logic hs;
    int   guard;
    repeat (gap) begin @(posedge clk); #1; end
    if (sel == 0) begin in_valid = 1'b1; in_data = b; end
    else          begin in_valid4 = 1'b1; in_data4 = b; end
    guard = 0;
    hs = 1'b0;
    while (!hs && guard < 50) begin
      @(negedge clk);
      hs = (sel == 0) ? in_ready : in_ready4;
      @(posedge clk); #1;
      guard++;
    end
    if (!hs) chk("handshake_timeout", 32'(guard), 32'd0);
    in_valid = 1'b0; in_valid4 = 1'b0;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] cnt, input int gm);
    send(sel, cnt, gapv(gm));
    foreach (fw[i]) begin
      send(sel, fw[i][15:8], gapv(gm));
      send(sel, fw[i][7:0], gapv(gm));
    end
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = '0;
      foreach (fw[i]) x = x ^ fw[i][15:8] ^ fw[i][7:0];
      send(sel, x, gapv(gm));
    end
`endif
  endtask

  task automatic wait_done(input int sel, input int target, input string nm);
    int g;
    g = 0;
    while (((sel == 0) ? done_cnt : done4_cnt) < target && g < 300) begin
      @(negedge clk); g++;
    end
    chk(nm, 32'((sel == 0) ? done_cnt : done4_cnt), 32'(target));
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input string nm);
    chk({nm, "_nwrites"}, 32'(wa_q.size()), 32'(fw.size()));
    foreach (fw[i]) begin
      if (i < wa_q.size()) begin
        if (wa_q[i] !== 8'(i) || wd_q[i] !== fw[i]) begin
          chk({nm, "_addr"}, 32'(wa_q[i]), 32'(i));
          chk({nm, "_data"}, 32'(wd_q[i]), 32'(fw[i]));
        end else begin
          n_chk++;
        end
      end
    end
  endtask

  typedef struct {
    int          nb;
    logic [7:0]  b[8];
    int          nw;
    logic [15:0] w[4];
  } vec_t;
  vec_t tbl[3];

  initial begin
    tbl[0].nb = 5; tbl[0].b = '{8'h02, 8'h10, 8'h00, 8'h14, 8'h21, 8'h00, 8'h00, 8'h00};
    tbl[0].nw = 2; tbl[0].w = '{16'h1000, 16'h1421, 16'h0000, 16'h0000};
    tbl[1].nb = 3; tbl[1].b = '{8'h01, 8'h47, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1].nw = 1; tbl[1].w = '{16'h4734, 16'h0000, 16'h0000, 16'h0000};
    tbl[2].nb = 7; tbl[2].b = '{8'h03, 8'hAA, 8'h55, 8'h00, 8'hFF, 8'h12, 8'h34, 8'h00};
    tbl[2].nw = 3; tbl[2].w = '{16'hAA55, 16'h00FF, 16'h1234, 16'h0000};

    // Reset values while rst is held
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr_wdata", 32'({imem_addr, imem_wdata}), 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_cpu_rst", 32'(cpu_rst), 32'd1);
    @(posedge clk); #1;

    // Vector table, back-to-back and with in_valid toggling
    for (int gm = 0; gm < 2; gm++) begin
      for (int t = 0; t < 3; t++) begin
        reset_dut();
        fw.delete();
        for (int k = 0; k < tbl[t].nw; k++) fw.push_back(tbl[t].w[k]);
        for (int j = 0; j < tbl[t].nb; j++) send(0, tbl[t].b[j], gm);
`ifdef LOADER_CHECKSUM_EN
        begin
          logic [7:0] x;
          x = '0;
          for (int j = 1; j < tbl[t].nb; j++) x = x ^ tbl[t].b[j];
          send(0, x, gm);
        end
`endif
        wait_done(0, 1, "tbl_done");
        check_frame("tbl");
        chk("tbl_cpu_rst_run", 32'(cpu_rst), 32'd0);
        chk("tbl_busy_run", 32'(busy), 32'd0);
        if (t == 0 && gm == 0 && wc_q.size() == 2) begin
          chk("we_spacing", 32'(wc_q[1] - wc_q[0]), 32'd2);
          chk("done_latency", 32'(done_cyc - wc_q[1]), 32'd1);
          chk("cpu_rst_at_done", 32'(rst_at_done), 32'd0);
        end
      end
    end

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum leaves the core in reset until rst
    reset_dut();
    send(0, 8'h01, 0); send(0, 8'h47, 0); send(0, 8'h34, 0); send(0, 8'h00, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bad_csum_err", 32'(err), 32'd1);
    chk("bad_csum_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("bad_csum_in_ready", 32'(in_ready), 32'd0);
    chk("bad_csum_no_done", 32'(done_cnt), 32'd0);
    @(posedge clk); #1;
    reset_dut();
    @(posedge clk); @(negedge clk);
    chk("bad_csum_cleared", 32'(err), 32'd0);
    @(posedge clk); #1;
`endif

    // N = 256 on an 8-bit IMEM: fills every address
    reset_dut();
    fw.delete();
    for (int i = 0; i < 256; i++) fw.push_back(16'($urandom));
    send_frame(0, 8'h00, 0);
    wait_done(0, 1, "full_done");
    check_frame("full");
    if (wa_q.size() == 256) chk("full_last_addr", 32'(wa_q[255]), 32'hFF);

    // IM_SIZE=4: oversize COUNT errors the next cycle with no write
    reset_dut();
    send(1, 8'h11, 0);
    @(negedge clk);
    chk("ovf_err", 32'(err4), 32'd1);
    chk("ovf_in_ready", 32'(in_ready4), 32'd0);
    chk("ovf_cpu_rst", 32'(cpu_rst4), 32'd1);
    chk("ovf_busy", 32'(busy4), 32'd0);
    repeat (5) @(posedge clk);
    #1 chk("ovf_no_we", 32'(we4_cnt), 32'd0);
    reset_dut();
    send(1, 8'h00, 0);
    @(negedge clk);
    chk("ovf256_err", 32'(err4), 32'd1);
    @(posedge clk); #1;

    // IM_SIZE=4: exactly 16 words is legal and ends at address F
    reset_dut();
    fw.delete();
    for (int i = 0; i < 16; i++) fw.push_back(16'($urandom));
    send_frame(1, 8'h10, 2);
    wait_done(1, 1, "n16_done");
    chk("n16_writes", 32'(we4_cnt), 32'd16);
    chk("n16_last_addr", 32'(last_a4), 32'hF);
    chk("n16_err", 32'(err4), 32'd0);

    // rst mid-load aborts; a fresh load then works
    reset_dut();
    send(0, 8'h03, 0); send(0, 8'hAB, 0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    clear_logs();
    fw.delete(); fw.push_back(16'h0000);
    send_frame(0, 8'h01, 0);
    wait_done(0, 1, "abort_reload_done");
    check_frame("abort_reload");

    // Random frames, consecutive loads without reset
    reset_dut();
    for (int f = 0; f < 6; f++) begin
      int n;
      n = int'($urandom_range(1, 12));
      fw.delete();
      for (int i = 0; i < n; i++) fw.push_back(16'($urandom));
      wa_q.delete(); wd_q.delete(); wc_q.delete(); done_cnt = 0;
      send_frame(0, 8'(n), 2);
      wait_done(0, 1, "rnd_done");
      check_frame("rnd");
      @(negedge clk);
      chk("rnd_cpu_rst", 32'(cpu_rst), 32'd0);
      chk("rnd_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end

    chk("in_ready_while_busy", 32'(busy_viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
